// File: rtl/nibble_spi_master_if.sv
// Handshake and serial-link bundle for nibble_spi_master.
// master = transmitter side, slave = feeder/receiver side.
interface nibble_spi_master_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic              done;

    modport master (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output sclk,
        output mosi,
        output cs_n,
        output busy,
        output done
    );

    modport slave (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  sclk,
        input  mosi,
        input  cs_n,
        input  busy,
        input  done
    );
endinterface

// File: rtl/nibble_spi_master.sv
// Mode-0 SPI transmitter: one DATA_W-bit frame per valid/ready handshake.
// Optional trailing even-parity bit when NIBBLE_SPI_PARITY_EN is defined.
module nibble_spi_master #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_W    = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_spi_master_if.master bus
);

`ifdef NIBBLE_SPI_PARITY_EN
    localparam int NB = DATA_W + 1;
`else
    localparam int NB = DATA_W;
`endif
    localparam int BW = $clog2(NB + 1);
    localparam logic [7:0]    HRELOAD = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST    = BW'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state, state_d;
    logic [7:0]    hcnt, hcnt_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic [NB-1:0] sreg, sreg_d;
    logic [NB-1:0] load;
    logic [NB-1:0] shifted;
    logic [DATA_W-1:0] data_ord;
    logic          tick;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    assign tick    = (hcnt == 8'd0);
    assign shifted = sreg << 1;

    // Arrange the frame so the first bit on the wire sits in the MSB.
    always_comb begin
        data_ord = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (MSB_FIRST != 0)
                data_ord[i] = bus.tx_data[i];
            else
                data_ord[DATA_W-1-i] = bus.tx_data[i];
        end
`ifdef NIBBLE_SPI_PARITY_EN
        load = {data_ord, ^bus.tx_data};
`else
        load = data_ord;
`endif
    end

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_d = state;
        hcnt_d  = tick ? hcnt : hcnt - 8'd1;
        bcnt_d  = bcnt;
        sreg_d  = sreg;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                hcnt_d = '0;
                bcnt_d = '0;
                if (bus.tx_valid && rdy_q) begin
                    state_d = SETUP;
                    hcnt_d  = HRELOAD;
                    sreg_d  = load;
                    mosi_d  = load[NB-1];
                    cs_n_d  = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    hcnt_d  = HRELOAD;
                    sclk_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    hcnt_d = HRELOAD;
                    if (sclk_q) begin
                        // Falling edge: present the next bit.
                        sclk_d = 1'b0;
                        if (bcnt != LAST) begin
                            sreg_d = shifted;
                            mosi_d = shifted[NB-1];
                        end
                    end else if (bcnt == LAST) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bcnt_d = bcnt + 1'b1;
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    hcnt_d  = HRELOAD;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset drops the frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hcnt   <= '0;
            bcnt   <= '0;
            sreg   <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= 1'b1;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            hcnt   <= hcnt_d;
            bcnt   <= bcnt_d;
            sreg   <= sreg_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_n_q <= cs_n_d;
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.mosi     = mosi_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.tx_ready = rdy_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
